// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, long-path handshake, issue/scoreboard
// query and the register-file write port. The arbiter uses the slave side.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_res;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  q_ra1;
  logic [4:0]  q_ra2;
  logic        busy1;
  logic        busy2;
  logic        stall_req;
  logic [4:0]  ra3;
  logic [31:0] wd3;
  logic        we3;
  logic        sb_err;

  modport slave (
    input  alu_valid, alu_rd, alu_res,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  iss_valid, iss_rd, q_ra1, q_ra2,
    output busy1, busy2, stall_req,
    output ra3, wd3, we3, sb_err
  );

  modport master (
    output alu_valid, alu_rd, alu_res,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output iss_valid, iss_rd, q_ra1, q_ra2,
    input  busy1, busy2, stall_req,
    input  ra3, wd3, we3, sb_err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the un-stallable ALU result and the long-latency
// valid/ready path (buffered in a small FIFO) onto the single register-file
// write port, and tracks pending long-latency destinations for RAW detection.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

  logic [4:0]  r_mem_rd   [DEPTH];
  logic [31:0] r_mem_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [31:0] r_pending;
  logic        r_sb_err;
  logic        r_src_ld;
  logic [4:0]  r_ra3;
  logic [31:0] r_wd3;
  logic        r_we3;

  logic        w_empty;
  logic        w_full;
  logic        w_ld_ready;
  logic        w_ld_keep;
  logic        w_alu_wr;
  logic        w_wr_en;
  logic [4:0]  w_wr_rd;
  logic [31:0] w_wr_data;
  logic        w_wr_src_ld;
  logic        w_pop;
  logic        w_direct;
  logic        w_push;
  logic        w_clr;
  logic        w_set;
  logic [31:0] w_pend_next;
  logic        w_err_dup;
  logic        w_err_orphan;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == LP_DEPTH);
  assign w_ld_ready = !w_full && !rst;
  // Accepted long-path results to x0 complete the handshake but are dropped.
  assign w_ld_keep  = bus.ld_valid && w_ld_ready && (bus.ld_rd != '0);
  assign w_alu_wr   = bus.alu_valid && (bus.alu_rd != '0);
  assign w_push     = w_ld_keep && !w_direct;

  // Select this cycle's writeback source: ALU, then FIFO head, then bypass.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_rd     = '0;
    w_wr_data   = '0;
    w_wr_src_ld = 1'b0;
    w_pop       = 1'b0;
    w_direct    = 1'b0;
    if (w_alu_wr) begin
      w_wr_en   = 1'b1;
      w_wr_rd   = bus.alu_rd;
      w_wr_data = bus.alu_res;
    end else if (!w_empty) begin
      w_wr_en     = 1'b1;
      w_wr_rd     = r_mem_rd[r_rptr];
      w_wr_data   = r_mem_data[r_rptr];
      w_wr_src_ld = 1'b1;
      w_pop       = 1'b1;
    end else if (w_ld_keep) begin
      w_wr_en     = 1'b1;
      w_wr_rd     = bus.ld_rd;
      w_wr_data   = bus.ld_data;
      w_wr_src_ld = 1'b1;
      w_direct    = 1'b1;
    end
  end

  // Scoreboard update: clear on the edge a long result hits the regfile,
  // set on issue; set is applied last so it wins on the same index.
  assign w_clr = r_we3 && r_src_ld;
  assign w_set = bus.iss_valid && (bus.iss_rd != '0);

  always_comb begin
    w_pend_next = r_pending;
    if (w_clr) w_pend_next[r_ra3] = 1'b0;
    if (w_set) w_pend_next[bus.iss_rd] = 1'b1;
  end

  assign w_err_dup    = w_set && r_pending[bus.iss_rd] && !(w_clr && (r_ra3 == bus.iss_rd));
  assign w_err_orphan = w_clr && !r_pending[r_ra3];

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= bus.ld_rd;
      r_mem_data[r_wptr] <= bus.ld_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LP_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + LP_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + LP_CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - LP_CNT_ONE;
    end
  end

  // Registered register-file write port and its source tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we3    <= 1'b0;
      r_ra3    <= '0;
      r_wd3    <= '0;
      r_src_ld <= 1'b0;
    end else begin
      r_we3    <= w_wr_en;
      r_ra3    <= w_wr_rd;
      r_wd3    <= w_wr_data;
      r_src_ld <= w_wr_src_ld;
    end
  end

  // Pending-destination bits and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_sb_err  <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      if (w_err_dup || w_err_orphan) r_sb_err <= 1'b1;
    end
  end

  assign bus.ld_ready  = w_ld_ready;
  assign bus.stall_req = w_full;
  assign bus.busy1     = r_pending[bus.q_ra1] && (bus.q_ra1 != '0);
  assign bus.busy2     = r_pending[bus.q_ra2] && (bus.q_ra2 != '0);
  assign bus.ra3       = r_ra3;
  assign bus.wd3       = r_wd3;
  assign bus.we3       = r_we3;
  assign bus.sb_err    = r_sb_err;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the writeback rules.
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  wb_arbiter_if bus_if ();

  wb_arbiter #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  // Behavioural model state.
  ent_t        m_q[$];
  logic [31:0] m_pend = '0;
  logic        m_we   = 1'b0;
  logic [4:0]  m_ra   = '0;
  logic [31:0] m_wd   = '0;
  logic        m_src  = 1'b0;
  logic        m_err  = 1'b0;

  function automatic logic exp_busy(input logic [4:0] q);
    return m_pend[q] && (q != 5'd0);
  endfunction

  function automatic logic exp_ld_ready();
    return (m_q.size() < DEPTH) && !rst;
  endfunction

  function automatic logic exp_stall();
    return m_q.size() == DEPTH;
  endfunction

  // Apply one clock edge of writeback rules to the model using current inputs.
  task automatic model_step();
    ent_t        e;
    logic        acc;
    logic        keep;
    logic        clr;
    logic        direct;
    logic [31:0] np;
    if (rst) begin
      m_q.delete();
      m_pend = '0; m_we = 1'b0; m_ra = '0; m_wd = '0; m_src = 1'b0; m_err = 1'b0;
      return;
    end
    acc  = bus_if.ld_valid && (m_q.size() < DEPTH);
    keep = acc && (bus_if.ld_rd != 5'd0);
    clr  = m_we && m_src;
    np   = m_pend;
    if (clr) begin
      if (!m_pend[m_ra]) m_err = 1'b1;
      np[m_ra] = 1'b0;
    end
    if (bus_if.iss_valid && bus_if.iss_rd != 5'd0) begin
      if (m_pend[bus_if.iss_rd] && !(clr && m_ra == bus_if.iss_rd)) m_err = 1'b1;
      np[bus_if.iss_rd] = 1'b1;
    end
    m_pend = np;
    direct = 1'b0;
    if (bus_if.alu_valid && bus_if.alu_rd != 5'd0) begin
      m_we = 1'b1; m_ra = bus_if.alu_rd; m_wd = bus_if.alu_res; m_src = 1'b0;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = 1'b1; m_ra = e.rd; m_wd = e.d; m_src = 1'b1;
    end else if (keep) begin
      m_we = 1'b1; m_ra = bus_if.ld_rd; m_wd = bus_if.ld_data; m_src = 1'b1;
      direct = 1'b1;
    end else begin
      m_we = 1'b0; m_src = 1'b0;
    end
    if (keep && !direct) m_q.push_back({bus_if.ld_rd, bus_if.ld_data});
  endtask

  // Advance one cycle; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.alu_valid = 1'b0; bus_if.alu_rd = '0; bus_if.alu_res = '0;
    bus_if.ld_valid  = 1'b0; bus_if.ld_rd  = '0; bus_if.ld_data = '0;
    bus_if.iss_valid = 1'b0; bus_if.iss_rd = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus_if.q_ra1 = 5'd5; bus_if.q_ra2 = 5'd0;
    rst = 1'b1;
    tick();
    tick();
    n_chk++; if (bus_if.ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ld_ready_low: got %b exp 0", bus_if.ld_ready); end
    n_chk++; if (bus_if.we3 !== 1'b0) begin n_err++; $display("FAIL rst_we3: got %b exp 0", bus_if.we3); end
    n_chk++; if (bus_if.ra3 !== 5'd0 || bus_if.wd3 !== 32'd0) begin n_err++; $display("FAIL rst_ra3_wd3: got %h/%h exp 0/0", bus_if.ra3, bus_if.wd3); end
    n_chk++; if (bus_if.sb_err !== 1'b0) begin n_err++; $display("FAIL rst_sb_err: got %b exp 0", bus_if.sb_err); end
    rst = 1'b0;
    #1;
    n_chk++; if (bus_if.ld_ready !== 1'b1) begin n_err++; $display("FAIL rst_ld_ready_after: got %b exp 1", bus_if.ld_ready); end
    n_chk++; if (bus_if.stall_req !== 1'b0 || bus_if.busy1 !== 1'b0) begin n_err++; $display("FAIL rst_stall_busy: got %b/%b exp 0/0", bus_if.stall_req, bus_if.busy1); end
  endtask

  task automatic test_alu();
    idle();
    bus_if.alu_valid = 1'b1; bus_if.alu_rd = 5'd5; bus_if.alu_res = 32'hDEADBEEF;
    tick();
    n_chk++; if (bus_if.we3 !== 1'b1 || bus_if.ra3 !== 5'd5 || bus_if.wd3 !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL alu_write: got we=%b rd=%0d d=%h exp 1/5/deadbeef", bus_if.we3, bus_if.ra3, bus_if.wd3); end
    bus_if.alu_rd = 5'd0; bus_if.alu_res = 32'h1;
    tick();
    n_chk++; if (bus_if.we3 !== 1'b0) begin n_err++; $display("FAIL alu_x0: got we3=%b exp 0", bus_if.we3); end
    idle();
    tick();
  endtask

  task automatic test_direct_load();
    idle();
    bus_if.iss_valid = 1'b1; bus_if.iss_rd = 5'd7; bus_if.q_ra1 = 5'd7;
    tick();
    bus_if.iss_valid = 1'b0;
    #1;
    n_chk++; if (bus_if.busy1 !== 1'b1) begin n_err++; $display("FAIL direct_busy_set: got %b exp 1", bus_if.busy1); end
    tick();
    bus_if.ld_valid = 1'b1; bus_if.ld_rd = 5'd7; bus_if.ld_data = 32'h12345678;
    #1;
    n_chk++; if (bus_if.ld_ready !== 1'b1) begin n_err++; $display("FAIL direct_ld_ready: got %b exp 1", bus_if.ld_ready); end
    tick();
    n_chk++; if (bus_if.we3 !== 1'b1 || bus_if.ra3 !== 5'd7 || bus_if.wd3 !== 32'h12345678)
      begin n_err++; $display("FAIL direct_write: got we=%b rd=%0d d=%h exp 1/7/12345678", bus_if.we3, bus_if.ra3, bus_if.wd3); end
    bus_if.ld_valid = 1'b0;
    tick();
    n_chk++; if (bus_if.busy1 !== 1'b0 || bus_if.sb_err !== 1'b0 || bus_if.we3 !== 1'b0)
      begin n_err++; $display("FAIL direct_clear: got busy1=%b err=%b we=%b exp 0/0/0", bus_if.busy1, bus_if.sb_err, bus_if.we3); end
  endtask

  task automatic test_contention();
    idle();
    for (int k = 1; k <= 4; k++) begin
      bus_if.iss_valid = 1'b1; bus_if.iss_rd = 5'(k);
      tick();
    end
    bus_if.iss_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus_if.alu_valid = 1'b1; bus_if.alu_rd = 5'(10 + k); bus_if.alu_res = 32'hC0DE0000 + 32'(k);
      bus_if.ld_valid  = 1'b1; bus_if.ld_rd  = 5'(k);      bus_if.ld_data = 32'hA0000000 + 32'(k);
      tick();
      n_chk++; if (bus_if.we3 !== 1'b1 || bus_if.ra3 !== 5'(10 + k))
        begin n_err++; $display("FAIL cont_alu_prio: got we=%b rd=%0d exp 1/%0d", bus_if.we3, bus_if.ra3, 10 + k); end
    end
    n_chk++; if (bus_if.stall_req !== 1'b1 || bus_if.ld_ready !== 1'b0)
      begin n_err++; $display("FAIL cont_full: got stall=%b rdy=%b exp 1/0", bus_if.stall_req, bus_if.ld_ready); end
    bus_if.alu_rd = 5'd15; bus_if.alu_res = 32'h55; bus_if.ld_rd = 5'd5; bus_if.ld_data = 32'hBAD;
    tick();
    n_chk++; if (bus_if.ra3 !== 5'd15 || bus_if.stall_req !== 1'b1 || bus_if.ld_ready !== 1'b0)
      begin n_err++; $display("FAIL cont_stall_hold: got rd=%0d stall=%b rdy=%b exp 15/1/0", bus_if.ra3, bus_if.stall_req, bus_if.ld_ready); end
    idle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_chk++; if (bus_if.we3 !== 1'b1 || bus_if.ra3 !== 5'(k) || bus_if.wd3 !== 32'hA0000000 + 32'(k))
        begin n_err++; $display("FAIL cont_drain: got we=%b rd=%0d d=%h exp 1/%0d/%h", bus_if.we3, bus_if.ra3, bus_if.wd3, k, 32'hA0000000 + 32'(k)); end
    end
    bus_if.q_ra1 = 5'd1; bus_if.q_ra2 = 5'd4;
    tick();
    n_chk++; if (bus_if.we3 !== 1'b0 || bus_if.busy1 !== 1'b0 || bus_if.busy2 !== 1'b0 || bus_if.sb_err !== 1'b0)
      begin n_err++; $display("FAIL cont_end: got we=%b b1=%b b2=%b err=%b exp 0/0/0/0", bus_if.we3, bus_if.busy1, bus_if.busy2, bus_if.sb_err); end
  endtask

  task automatic test_collision();
    idle();
    bus_if.iss_valid = 1'b1; bus_if.iss_rd = 5'd9; bus_if.q_ra1 = 5'd9;
    tick();
    idle();
    bus_if.ld_valid = 1'b1; bus_if.ld_rd = 5'd9; bus_if.ld_data = 32'h99;
    tick();
    idle();
    bus_if.iss_valid = 1'b1; bus_if.iss_rd = 5'd9;
    tick();
    idle();
    #1;
    n_chk++; if (bus_if.busy1 !== 1'b1 || bus_if.sb_err !== 1'b0)
      begin n_err++; $display("FAIL collision: got busy1=%b err=%b exp 1/0", bus_if.busy1, bus_if.sb_err); end
  endtask

  task automatic test_errors();
    do_reset();
    bus_if.iss_valid = 1'b1; bus_if.iss_rd = 5'd3;
    tick();
    tick();
    idle();
    #1;
    n_chk++; if (bus_if.sb_err !== 1'b1) begin n_err++; $display("FAIL err_dup_issue: got %b exp 1", bus_if.sb_err); end
    do_reset();
    n_chk++; if (bus_if.sb_err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b exp 0", bus_if.sb_err); end
    bus_if.ld_valid = 1'b1; bus_if.ld_rd = 5'd6; bus_if.ld_data = 32'h66;
    tick();
    n_chk++; if (bus_if.we3 !== 1'b1 || bus_if.ra3 !== 5'd6) begin n_err++; $display("FAIL err_orphan_write: got we=%b rd=%0d exp 1/6", bus_if.we3, bus_if.ra3); end
    idle();
    tick();
    n_chk++; if (bus_if.sb_err !== 1'b1) begin n_err++; $display("FAIL err_orphan: got %b exp 1", bus_if.sb_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      bus_if.iss_valid = 1'b1; bus_if.iss_rd = 5'(k);
      tick();
    end
    bus_if.iss_rd = 5'd8;
    tick();
    bus_if.iss_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus_if.alu_valid = 1'b1; bus_if.alu_rd = 5'd20; bus_if.alu_res = 32'(k);
      bus_if.ld_valid  = 1'b1; bus_if.ld_rd  = 5'(k); bus_if.ld_data = 32'hF00 + 32'(k);
      tick();
    end
    bus_if.q_ra1 = 5'd1; bus_if.q_ra2 = 5'd8;
    #1;
    n_chk++; if (bus_if.busy1 !== 1'b1 || bus_if.busy2 !== 1'b1 || bus_if.we3 !== 1'b1)
      begin n_err++; $display("FAIL mid_pre: got b1=%b b2=%b we=%b exp 1/1/1", bus_if.busy1, bus_if.busy2, bus_if.we3); end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_chk++; if (bus_if.we3 !== 1'b0 || bus_if.busy1 !== 1'b0 || bus_if.busy2 !== 1'b0 || bus_if.ld_ready !== 1'b1)
      begin n_err++; $display("FAIL mid_post: got we=%b b1=%b b2=%b rdy=%b exp 0/0/0/1", bus_if.we3, bus_if.busy1, bus_if.busy2, bus_if.ld_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++; if (bus_if.we3 !== 1'b0) begin n_err++; $display("FAIL mid_stale: cycle %0d got we3=%b exp 0", k, bus_if.we3); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst              = ($urandom_range(0, 59) == 0);
      bus_if.alu_valid = ($urandom_range(0, 2) == 0);
      bus_if.alu_rd    = 5'($urandom_range(0, 7));
      bus_if.alu_res   = $urandom;
      bus_if.ld_valid  = ($urandom_range(0, 1) == 0);
      bus_if.ld_rd     = 5'($urandom_range(0, 7));
      bus_if.ld_data   = $urandom;
      bus_if.iss_valid = ($urandom_range(0, 2) == 0);
      bus_if.iss_rd    = 5'($urandom_range(0, 7));
      bus_if.q_ra1     = 5'($urandom_range(0, 7));
      bus_if.q_ra2     = 5'($urandom_range(0, 7));
      tick();
      n_chk++; if (bus_if.we3 !== m_we) begin n_err++; $display("FAIL rnd_we3 @%0d: got %b exp %b", i, bus_if.we3, m_we); end
      if (m_we) begin
        n_chk++; if (bus_if.ra3 !== m_ra || bus_if.wd3 !== m_wd)
          begin n_err++; $display("FAIL rnd_data @%0d: got %0d/%h exp %0d/%h", i, bus_if.ra3, bus_if.wd3, m_ra, m_wd); end
      end
      n_chk++; if (bus_if.sb_err !== m_err) begin n_err++; $display("FAIL rnd_sb_err @%0d: got %b exp %b", i, bus_if.sb_err, m_err); end
      n_chk++; if (bus_if.ld_ready !== exp_ld_ready() || bus_if.stall_req !== exp_stall())
        begin n_err++; $display("FAIL rnd_flow @%0d: got rdy=%b stall=%b exp %b/%b", i, bus_if.ld_ready, bus_if.stall_req, exp_ld_ready(), exp_stall()); end
      n_chk++; if (bus_if.busy1 !== exp_busy(bus_if.q_ra1) || bus_if.busy2 !== exp_busy(bus_if.q_ra2))
        begin n_err++; $display("FAIL rnd_busy @%0d: got %b/%b exp %b/%b", i, bus_if.busy1, bus_if.busy2, exp_busy(bus_if.q_ra1), exp_busy(bus_if.q_ra2)); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.q_ra1 = '0;
    bus_if.q_ra2 = '0;
    idle();
    test_reset();
    test_alu();
    test_direct_load();
    test_contention();
    test_collision();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
